// File: rtl/pulse_stretch_arbiter.sv
// Round-robin arbiter that latches single-cycle event strobes and grants
// one fixed-length stretched pulse on o_y per event, separated by a gap.
module pulse_stretch_arbiter #(
  parameter int par_num_req        = 4,
  parameter int par_req_bits       = 2,
  parameter int par_T_stretch_bits = 7,
  parameter int par_T_stretch_val  = 64,
  parameter int par_T_gap_val      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [par_num_req-1:0]  i_x,
  input  logic                    i_enable,
  input  logic                    i_clr_overrun,
  output logic                    o_y,
  output logic [par_req_bits-1:0] o_grant_id,
  output logic [par_num_req-1:0]  o_pending,
  output logic [par_num_req-1:0]  o_overrun,
  output logic                    o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_STRETCH = 2'b01,
    ST_GAP     = 2'b10
  } state_t;

  localparam int TW = par_T_stretch_bits;

  localparam logic [TW-1:0] lp_str_last =
    TW'(par_T_stretch_val - 1);
  localparam logic [TW-1:0] lp_gap_last =
    TW'(par_T_gap_val - 1);
  localparam logic [TW-1:0] lp_t_max = '1;
  localparam logic [TW-1:0] lp_t_one = TW'(1);
  localparam logic [par_req_bits-1:0] lp_gid_rst =
    par_req_bits'(par_num_req - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [TW-1:0]           r_timer;
  logic                    r_y;
  logic [par_req_bits-1:0] r_grant;
  logic [par_num_req-1:0]  r_pending;
  logic [par_num_req-1:0]  r_overrun;

  logic [par_req_bits-1:0] w_win;
  logic [par_req_bits-1:0] w_idx;
  int                      w_sum;
  logic                    w_found;
  logic                    w_grant_go;
  logic [par_num_req-1:0]  w_clr;
  logic [par_num_req-1:0]  w_ovr_set;

  // Search starts one past the last owner and wraps around.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_grant;
    w_idx   = '0;
    w_sum   = 0;
    for (int i = 1; i <= par_num_req; i++) begin
      w_sum = (int'(r_grant) + i) % par_num_req;
      w_idx = par_req_bits'(w_sum);
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_grant_go = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_enable && w_found) begin
          w_next     = ST_STRETCH;
          w_grant_go = 1'b1;
        end
      end
      ST_STRETCH: begin
        if (r_timer == lp_str_last) begin
          w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_timer == lp_gap_last) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // A new strobe in the grant cycle re-arms the bit instead of overrunning.
  always_comb begin
    w_clr = '0;
    if (w_grant_go) begin
      w_clr[w_win] = 1'b1;
    end
    w_ovr_set = i_x & r_pending & ~w_clr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_y     <= 1'b0;
      r_grant <= lp_gid_rst;
    end else begin
      r_state <= w_next;
      r_y     <= (w_next == ST_STRETCH);
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (r_timer != lp_t_max) begin
        r_timer <= r_timer + lp_t_one;
      end
      if (w_grant_go) begin
        r_grant <= w_win;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= i_x | (r_pending & ~w_clr);
      r_overrun <= (i_clr_overrun ? '0 : r_overrun)
                 | w_ovr_set;
    end
  end

  assign o_y        = r_y;
  assign o_grant_id = r_grant;
  assign o_pending  = r_pending;
  assign o_overrun  = r_overrun;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pulse_stretch_arbiter.sv
// Directed bench for pulse_stretch_arbiter: vector table plus
// hand-written sequences for bursts, overrun, set-wins and reset.
module tb_pulse_stretch_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic       en;
  logic       clr;
  logic       y;
  logic [1:0] gid;
  logic [3:0] pend;
  logic [3:0] ov;
  logic       busy;

  int n_cmp;
  int n_err;
  int cyc;

  int nb;
  int b_gid[8];
  int b_hi[8];
  int b_lo[8];

  typedef struct {
    logic [3:0] x;
    logic       en;
    logic       clr;
    int         adv;
    logic       y;
    logic [3:0] pend;
    logic [3:0] ov;
    logic       busy;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl[12];

  pulse_stretch_arbiter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_x           (x),
    .i_enable      (en),
    .i_clr_overrun (clr),
    .o_y           (y),
    .o_grant_id    (gid),
    .o_pending     (pend),
    .o_overrun     (ov),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " y"},    32'(y),    32'(0));
    check({tag, " busy"}, 32'(busy), 32'(0));
    check({tag, " pend"}, 32'(pend), 32'(0));
    check({tag, " ov"},   32'(ov),   32'(0));
    check({tag, " gid"},  32'(gid),  32'(3));
  endtask

  task automatic do_reset();
    x     = '0;
    clr   = 1'b0;
    en    = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Records each completed burst: owner at rise, high run, low run before it.
  task automatic monitor(input int budget);
    logic prev;
    int   run;
    nb   = 0;
    prev = y;
    run  = 0;
    for (int i = 0; i < 8; i++) begin
      b_gid[i] = -1;
      b_hi[i]  = 0;
      b_lo[i]  = 0;
    end
    for (int c = 0; c < budget; c++) begin
      step();
      if (y != prev) begin
        if (y) begin
          if (nb < 8) begin
            b_gid[nb] = int'(gid);
            b_lo[nb]  = run;
          end
        end else begin
          if (nb < 8) b_hi[nb] = run;
          nb++;
        end
        run = 1;
      end else begin
        run++;
      end
      prev = y;
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] vx, input logic ven,
    input logic vclr, input int vadv,
    input logic vy, input logic [3:0] vp,
    input logic [3:0] vo, input logic vb,
    input logic [1:0] vg);
    vec_t v;
    v.x = vx; v.en = ven; v.clr = vclr; v.adv = vadv;
    v.y = vy; v.pend = vp; v.ov = vo;
    v.busy = vb; v.gid = vg;
    return v;
  endfunction

  initial begin
    int cnt2;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    x     = '0;
    en    = 1'b1;
    clr   = 1'b0;
    rst_n = 1'b1;

    // single event, then enable gating
    tbl[0]  = mk(4'b0001, 1, 0, 1,  0, 4'b0001, 0, 0, 3);
    tbl[1]  = mk(4'b0000, 1, 0, 1,  1, 4'b0000, 0, 1, 0);
    tbl[2]  = mk(4'b0000, 1, 0, 63, 1, 4'b0000, 0, 1, 0);
    tbl[3]  = mk(4'b0000, 1, 0, 1,  0, 4'b0000, 0, 1, 0);
    tbl[4]  = mk(4'b0000, 1, 0, 3,  0, 4'b0000, 0, 1, 0);
    tbl[5]  = mk(4'b0000, 1, 0, 1,  0, 4'b0000, 0, 0, 0);
    tbl[6]  = mk(4'b0010, 0, 0, 1,  0, 4'b0010, 0, 0, 0);
    tbl[7]  = mk(4'b0000, 0, 0, 5,  0, 4'b0010, 0, 0, 0);
    tbl[8]  = mk(4'b0000, 1, 0, 1,  1, 4'b0000, 0, 1, 1);
    tbl[9]  = mk(4'b0000, 1, 0, 63, 1, 4'b0000, 0, 1, 1);
    tbl[10] = mk(4'b0000, 1, 0, 1,  0, 4'b0000, 0, 1, 1);
    tbl[11] = mk(4'b0000, 1, 0, 4,  0, 4'b0000, 0, 0, 1);

    #1 rst_n = 1'b0;
    #2;
    check_reset_vals("rst async");
    step();
    step();
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 10) step();
    check_reset_vals("rst idle");

    for (int v = 0; v < 12; v++) begin
      x   = tbl[v].x;
      en  = tbl[v].en;
      clr = tbl[v].clr;
      for (int s = 0; s < tbl[v].adv; s++) begin
        step();
        x   = '0;
        clr = 1'b0;
      end
      check($sformatf("v%0d y", v),    32'(y),    32'(tbl[v].y));
      check($sformatf("v%0d pend", v), 32'(pend), 32'(tbl[v].pend));
      check($sformatf("v%0d ov", v),   32'(ov),   32'(tbl[v].ov));
      check($sformatf("v%0d busy", v), 32'(busy), 32'(tbl[v].busy));
      check($sformatf("v%0d gid", v),  32'(gid),  32'(tbl[v].gid));
    end

    // all four requesters at once
    do_reset();
    x = 4'b1111;
    step();
    x = '0;
    check("all pend", 32'(pend), 32'(4'b1111));
    monitor(330);
    check("all nb", 32'(nb), 32'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("all gid%0d", i), 32'(b_gid[i]), 32'(i));
      check($sformatf("all hi%0d", i),  32'(b_hi[i]),  32'(64));
      if (i > 0)
        check($sformatf("all lo%0d", i), 32'(b_lo[i]), 32'(5));
    end
    check("all ov", 32'(ov), 32'(0));

    // overrun on requester 2 during requester 0's burst
    do_reset();
    x = 4'b0001;
    step();
    x = '0;
    step();
    check("ovr y0", 32'(y), 32'(1));
    repeat (5) step();
    x = 4'b0100;
    step();
    x = '0;
    check("ovr first", 32'(ov), 32'(0));
    repeat (3) step();
    x = 4'b0100;
    step();
    x = '0;
    check("ovr set", 32'(ov), 32'(4'b0100));
    check("ovr pend", 32'(pend), 32'(4'b0100));
    monitor(200);
    cnt2 = 0;
    for (int i = 0; i < 8; i++)
      if (b_gid[i] == 2) cnt2++;
    check("ovr bursts2", 32'(cnt2), 32'(1));
    check("ovr nb", 32'(nb), 32'(2));
    check("ovr sticky", 32'(ov), 32'(4'b0100));
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("ovr clr", 32'(ov), 32'(0));
    en = 1'b0;
    x  = 4'b0100;
    step();
    check("clr pend", 32'(pend), 32'(4'b0100));
    x   = 4'b0100;
    clr = 1'b1;
    step();
    x = '0;
    check("clr set wins", 32'(ov), 32'(4'b0100));
    step();
    clr = 1'b0;
    check("clr again", 32'(ov), 32'(0));
    en = 1'b1;

    // strobe in own grant cycle re-arms pending
    do_reset();
    x = 4'b0010;
    step();
    check("sw pend", 32'(pend), 32'(4'b0010));
    x = 4'b0010;
    step();
    x = '0;
    check("sw y", 32'(y), 32'(1));
    check("sw gid", 32'(gid), 32'(1));
    check("sw repend", 32'(pend), 32'(4'b0010));
    check("sw ov", 32'(ov), 32'(0));
    monitor(200);
    check("sw nb", 32'(nb), 32'(2));
    check("sw gid2", 32'(b_gid[1]), 32'(1));
    check("sw lo2", 32'(b_lo[1]), 32'(5));
    check("sw ov end", 32'(ov), 32'(0));

    // reset in the middle of a burst
    do_reset();
    x = 4'b1000;
    step();
    x = '0;
    step();
    check("mid y", 32'(y), 32'(1));
    check("mid gid", 32'(gid), 32'(3));
    x = 4'b0110;
    step();
    x = '0;
    repeat (27) step();
    check("mid y30", 32'(y), 32'(1));
    check("mid pend", 32'(pend), 32'(4'b0110));
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("mid rst");
    step();
    check_reset_vals("mid hold");
    rst_n = 1'b1;
    x = 4'b1010;
    step();
    x = '0;
    check("post pend", 32'(pend), 32'(4'b1010));
    step();
    check("post y", 32'(y), 32'(1));
    check("post gid", 32'(gid), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
